seq_detect_param: RTL and testbench

Parametrised serial sequence detector, successor to the fixed 3-bit Mealy detector. It detects a runtime-programmable PAT_W-bit pattern on a 1-bit serial stream with a sample-enable qualifier. Overlapping or non-overlapping matching is selectable, as is Mealy (same-cycle) or registered (next-cycle) output. It also keeps a saturating match counter, and sits between the serial front-end and the status/interrupt logic.

---
 rtl/seq_detect_param_if.sv | 26 ++
 rtl/seq_detect_param.sv | 73 +++++++
 tb/tb_seq_detect_param.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_param_if.sv
// Serial-stream bus for seq_detect_param: sample/control inputs plus match pulse and counter.
// The bench drives through master; the detector connects as slave.
interface seq_detect_param_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  logic             in;
  logic             en;
  logic             overlap;
  logic             mealy_sel;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in, en, overlap, mealy_sel, pat_load, pat_in, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  in, en, overlap, mealy_sel, pat_load, pat_in, cnt_clr,
    output out, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Programmable PAT_W-bit serial pattern detector with overlap/non-overlap matching,
// Mealy or registered match pulse, and a saturating match counter.
module seq_detect_param #(
  parameter int               PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int               CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_param_if.slave bus
);

  localparam int               FILL_W      = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_PRIMED = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  logic [PAT_W-1:0]  pat_reg;
  logic [PAT_W-1:0]  hist;
  logic [PAT_W-1:0]  nhist;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic              out_r;
  logic              sample;
  logic              hit;
  logic [CNT_W-1:0]  cnt;

  // A match needs PAT_W-1 older valid bits plus the incoming one; a pattern
  // load in the same cycle discards the sample.
  always_comb begin
    nhist     = {hist[PAT_W-2:0], bus.in};
    sample    = bus.en && !bus.pat_load;
    hit       = sample && (fill >= FILL_PRIMED) && (nhist == pat_reg);
    fill_next = fill;
    if (hit && !bus.overlap) begin
      fill_next = '0;
    end else if (fill != FILL_FULL) begin
      fill_next = fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg <= PATTERN;
      hist    <= '0;
      fill    <= '0;
      out_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (bus.pat_load) begin
        pat_reg <= bus.pat_in;
        hist    <= '0;
        fill    <= '0;
      end else if (bus.en) begin
        hist <= nhist;
        fill <= fill_next;
      end

      out_r <= hit;

      // A clear coincident with a hit leaves that hit counted.
      if (bus.cnt_clr) begin
        cnt <= hit ? CNT_W'(1) : '0;
      end else if (hit && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out       = rst && (bus.mealy_sel ? hit : out_r);
  assign bus.match_cnt = cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param: one 8-bit-counter instance
// and one 2-bit-counter instance driven from the same stimulus.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_s = 1'b0;
  logic       en_s = 1'b0;
  logic       overlap_s = 1'b1;
  logic       mealy_s = 1'b1;
  logic       pat_load_s = 1'b0;
  logic [2:0] pat_in_s = 3'b000;
  logic       cnt_clr_s = 1'b0;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_W(3), .CNT_W(8)) a_if ();
  seq_detect_param_if #(.PAT_W(3), .CNT_W(2)) b_if ();

  assign a_if.in        = in_s;
  assign a_if.en        = en_s;
  assign a_if.overlap   = overlap_s;
  assign a_if.mealy_sel = mealy_s;
  assign a_if.pat_load  = pat_load_s;
  assign a_if.pat_in    = pat_in_s;
  assign a_if.cnt_clr   = cnt_clr_s;

  assign b_if.in        = in_s;
  assign b_if.en        = en_s;
  assign b_if.overlap   = overlap_s;
  assign b_if.mealy_sel = mealy_s;
  assign b_if.pat_load  = pat_load_s;
  assign b_if.pat_in    = pat_in_s;
  assign b_if.cnt_clr   = cnt_clr_s;

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) begin
      passed = passed + 1;
    end else begin
      failed = failed + 1;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic e);
    in_s = v;
    en_s = e;
    #1;
  endtask

  task automatic bitStep(input int sel, input logic v, input logic exp_out, input string tag);
    applyStimulus(v, 1'b1);
    checkOutput(tag, (sel == 1) ? b_if.out : a_if.out, exp_out);
    tick();
  endtask

  task automatic doReset();
    rst = 1'b0;
    en_s = 1'b0;
    pat_load_s = 1'b0;
    cnt_clr_s = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  bit stream7[7] = '{1, 0, 1, 0, 1, 0, 1};
  bit exp_ov[7]  = '{0, 0, 1, 0, 1, 0, 1};
  bit exp_nov[7] = '{0, 0, 1, 0, 0, 0, 1};
  bit stream9[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
  bit exp9[9]    = '{0, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    tick();
    doReset();
    #1;
    checkOutput("reset_out_a", a_if.out, 0);
    checkOutput("reset_cnt_a", a_if.match_cnt, 0);
    checkOutput("reset_cnt_b", b_if.match_cnt, 0);

    overlap_s = 1'b1;
    mealy_s   = 1'b1;
    for (int i = 0; i < 7; i++) bitStep(0, stream7[i], exp_ov[i], $sformatf("t1_bit%0d", i + 1));
    checkOutput("t1_cnt", a_if.match_cnt, 3);

    doReset();
    overlap_s = 1'b0;
    for (int i = 0; i < 7; i++) bitStep(0, stream7[i], exp_nov[i], $sformatf("t2_bit%0d", i + 1));
    checkOutput("t2_cnt", a_if.match_cnt, 2);

    doReset();
    overlap_s = 1'b1;
    mealy_s   = 1'b0;
    bitStep(0, 1'b1, 1'b0, "t3_bit1");
    bitStep(0, 1'b0, 1'b0, "t3_bit2");
    bitStep(0, 1'b1, 1'b0, "t3_bit3");
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_delayed", a_if.out, 1);
    mealy_s = 1'b1;
    #1;
    checkOutput("t3_switch", a_if.out, 0);
    mealy_s = 1'b0;
    #1;
    tick();
    checkOutput("t3_after", a_if.out, 0);

    doReset();
    mealy_s = 1'b1;
    bitStep(0, 1'b1, 1'b0, "t4_bit1");
    for (int g = 0; g < 3; g++) begin
      applyStimulus(g[0], 1'b0);
      checkOutput($sformatf("t4_gapA%0d", g), a_if.out, 0);
      tick();
    end
    bitStep(0, 1'b0, 1'b0, "t4_bit2");
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput($sformatf("t4_gapB%0d", g), a_if.out, 0);
      tick();
    end
    bitStep(0, 1'b1, 1'b1, "t4_bit3");
    checkOutput("t4_cnt", a_if.match_cnt, 1);

    doReset();
    bitStep(0, 1'b1, 1'b0, "t5_pre1");
    bitStep(0, 1'b0, 1'b0, "t5_pre2");
    pat_load_s = 1'b1;
    pat_in_s   = 3'b110;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_load_out", a_if.out, 0);
    tick();
    pat_load_s = 1'b0;
    bitStep(0, 1'b1, 1'b0, "t5_bit1");
    bitStep(0, 1'b1, 1'b0, "t5_bit2");
    bitStep(0, 1'b0, 1'b1, "t5_bit3");
    checkOutput("t5_cnt", a_if.match_cnt, 1);

    doReset();
    overlap_s = 1'b1;
    mealy_s   = 1'b1;
    for (int i = 0; i < 9; i++) bitStep(1, stream9[i], exp9[i], $sformatf("t6_bit%0d", i + 1));
    checkOutput("t6_sat", b_if.match_cnt, 3);
    bitStep(1, 1'b0, 1'b0, "t6_pre_clr");
    cnt_clr_s = 1'b1;
    bitStep(1, 1'b1, 1'b1, "t6_clr_hit");
    cnt_clr_s = 1'b0;
    checkOutput("t6_clr_cnt", b_if.match_cnt, 1);
    bitStep(1, 1'b1, 1'b0, "t6_mid1");
    bitStep(1, 1'b0, 1'b0, "t6_mid2");
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_rst_out", b_if.out, 0);
    tick();
    checkOutput("t6_rst_cnt", b_if.match_cnt, 0);
    rst = 1'b1;
    bitStep(1, 1'b1, 1'b0, "t6_post_rst");
    checkOutput("t6_post_cnt", b_if.match_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
